// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch control around the PC register.
// Issues single-outstanding imem requests, captures responses into IF/ID,
// parks a response in a one-entry skid buffer while decode stalls, and
// drains stale responses after a redirect.
// Optional build macro: FETCH_ALIGN_CHECK_EN (sticky misaligned-redirect flag).
module fetch_sequencer #(
  parameter logic [31:0] PC_STEP   = 32'd4,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_q,
  output logic [31:0] pc_d,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        id_stall,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc_plus4,
  output logic        addr_err
);

  // ISSUE: request this cycle; WAIT: response pending; HOLD: skid full;
  // KILL: a response for an abandoned request is still in flight.
  typedef enum logic [1:0] {
    ISSUE,
    WAIT,
    HOLD,
    KILL
  } state_t;

  state_t      state;
  logic [31:0] skid_instr;
  logic [31:0] pc_next_seq;
  logic [31:0] target_aligned;
  logic        take_resp;
  logic        take_skid;
  logic        load_ifid;

  assign pc_next_seq    = pc_q + PC_STEP;
  assign target_aligned = {redirect_target[31:2], 2'b00};
  assign imem_req       = (state == ISSUE) & ~reset;
  assign imem_addr      = pc_q;
  assign load_ifid      = take_resp | take_skid;

  // Decide whether a word enters IF/ID this cycle; a redirect suppresses both sources.
  always_comb begin
    take_resp = 1'b0;
    take_skid = 1'b0;
    if (!redirect_valid) begin
      take_resp = (state == WAIT) & imem_rvalid & (~id_stall | ~ifid_valid);
      take_skid = (state == HOLD) & ~id_stall;
    end
  end

  // Next PC: redirect wins, advance only when an instruction is consumed, else hold.
  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = target_aligned;
    end else if (load_ifid) begin
      pc_d = pc_next_seq;
    end
  end

  // Fetch FSM together with the IF/ID register and the skid buffer.
  // HOLD is the only state in which skid_instr holds a live word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ISSUE;
      ifid_valid    <= 1'b0;
      ifid_instr    <= NOP_INSTR;
      ifid_pc       <= '0;
      ifid_pc_plus4 <= '0;
      skid_instr    <= NOP_INSTR;
    end else begin
      unique case (state)
        ISSUE: state <= redirect_valid ? KILL : WAIT;
        WAIT: begin
          if (imem_rvalid) begin
            state <= (redirect_valid || take_resp) ? ISSUE : HOLD;
          end else if (redirect_valid) begin
            state <= KILL;
          end
        end
        HOLD: begin
          if (redirect_valid || !id_stall) begin
            state <= ISSUE;
          end
        end
        KILL: begin
          if (imem_rvalid) begin
            state <= ISSUE;
          end
        end
      endcase

      if (redirect_valid) begin
        skid_instr <= NOP_INSTR;
      end else if (state == WAIT && imem_rvalid && !take_resp) begin
        skid_instr <= imem_rdata;
      end

      if (redirect_valid) begin
        ifid_valid <= 1'b0;
        ifid_instr <= NOP_INSTR;
      end else if (load_ifid) begin
        ifid_valid    <= 1'b1;
        ifid_instr    <= take_resp ? imem_rdata : skid_instr;
        ifid_pc       <= pc_q;
        ifid_pc_plus4 <= pc_next_seq;
      end else if (!id_stall) begin
        ifid_valid <= 1'b0;
        ifid_instr <= NOP_INSTR;
      end
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  // Sticky flag for any redirect to a non-word-aligned target.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_err <= 1'b0;
    end else if (redirect_valid && (redirect_target[1:0] != 2'b00)) begin
      addr_err <= 1'b1;
    end
  end
`else
  assign addr_err = 1'b0;
  logic unused_target_lo;
  assign unused_target_lo = ^redirect_target[1:0];
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed bench with a PC register, a fixed-latency
// instruction memory and a transaction-level reference model.
`timescale 1ns/1ps
module tb_fetch_sequencer;

  localparam logic [31:0] NOP = 32'h0000_0000;
`ifdef FETCH_ALIGN_CHECK_EN
  localparam logic ALIGN_EN = 1'b1;
`else
  localparam logic ALIGN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        id_stall;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc_plus4;
  logic        addr_err;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned mem_delay = 1;

  always #5 clk = ~clk;

  fetch_sequencer #(.PC_STEP(32'd4), .NOP_INSTR(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .pc_q(pc_q), .pc_d(pc_d),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .id_stall(id_stall), .ifid_valid(ifid_valid), .ifid_instr(ifid_instr),
    .ifid_pc(ifid_pc), .ifid_pc_plus4(ifid_pc_plus4), .addr_err(addr_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // PC register: loads D every edge, forced to 0 under reset.
  initial begin : pc_reg
    logic [31:0] nxt;
    pc_q = '0;
    forever begin
      @(negedge clk);
      nxt = reset ? 32'h0 : pc_d;
      @(posedge clk);
      #1;
      pc_q = nxt;
    end
  end

  // Instruction memory: rdata = addr ^ A5A5_0000, mem_delay cycles after the request.
  initial begin : memory
    logic        req_s;
    logic [31:0] addr_s;
    logic [31:0] pend_addr;
    int unsigned cnt;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    pend_addr   = '0;
    cnt         = 0;
    forever begin
      @(negedge clk);
      req_s  = imem_req;
      addr_s = imem_addr;
      @(posedge clk);
      #1;
      imem_rvalid = 1'b0;
      if (reset) begin
        cnt = 0;
      end else begin
        if (cnt != 0) begin
          cnt--;
          if (cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = pend_addr ^ 32'hA5A5_0000;
          end
        end
        if (req_s === 1'b1) begin
          pend_addr = addr_s;
          if (mem_delay <= 1) begin
            imem_rvalid = 1'b1;
            imem_rdata  = pend_addr ^ 32'hA5A5_0000;
          end else begin
            cnt = mem_delay - 1;
          end
        end
      end
    end
  end

  // Reference model: outstanding requests as a queue of (addr, stale),
  // buffered words as a queue; compared against the DUT every cycle.
  typedef struct packed {
    logic [31:0] addr;
    logic        stale;
  } req_t;

  req_t        pend[$];
  logic [31:0] skid[$];
  logic [31:0] m_pc, m_instr, m_ipc, m_ip4;
  logic        m_ifv, m_err;
  bit          m_live = 0;

  initial begin : model
    logic        exp_req, live_head, accept, drain, has_r;
    logic [31:0] exp_pcd;
    req_t        r;
    m_pc = '0; m_instr = NOP; m_ipc = '0; m_ip4 = '0; m_ifv = 1'b0; m_err = 1'b0;
    forever begin
      @(negedge clk);
      exp_req   = !reset && pend.size() == 0 && skid.size() == 0;
      live_head = 1'b0;
      if (pend.size() != 0) live_head = !pend[0].stale;
      accept = imem_rvalid && live_head && (!id_stall || !m_ifv);
      drain  = skid.size() != 0 && !id_stall;
      if (redirect_valid)       exp_pcd = {redirect_target[31:2], 2'b00};
      else if (accept || drain) exp_pcd = m_pc + 32'd4;
      else                      exp_pcd = m_pc;

      if (m_live) begin
        chk("imem_req", imem_req, exp_req);
        if (exp_req) chk("imem_addr", imem_addr, m_pc);
        if (!reset) chk("pc_d", pc_d, exp_pcd);
        chk("ifid_valid", ifid_valid, m_ifv);
        chk("ifid_instr", ifid_instr, m_instr);
        if (m_ifv) begin
          chk("ifid_pc", ifid_pc, m_ipc);
          chk("ifid_pc_plus4", ifid_pc_plus4, m_ip4);
        end
        chk("addr_err", addr_err, m_err);
      end

      if (reset) begin
        pend.delete(); skid.delete();
        m_pc = '0; m_ifv = 1'b0; m_instr = NOP; m_ipc = '0; m_ip4 = '0; m_err = 1'b0;
        m_live = 1;
      end else begin
        has_r = 1'b0;
        r = '0;
        if (imem_rvalid && pend.size() != 0) begin
          r = pend.pop_front();
          has_r = 1'b1;
        end
        if (exp_req) pend.push_back('{addr: m_pc, stale: redirect_valid});
        if (redirect_valid) begin
          for (int i = 0; i < pend.size(); i++) pend[i].stale = 1'b1;
          skid.delete();
          m_ifv = 1'b0;
          m_instr = NOP;
          if (ALIGN_EN && redirect_target[1:0] != 2'b00) m_err = 1'b1;
        end else if (accept) begin
          m_ifv = 1'b1; m_instr = imem_rdata; m_ipc = m_pc; m_ip4 = m_pc + 32'd4;
        end else if (has_r && !r.stale) begin
          skid.push_back(imem_rdata);
        end else if (drain) begin
          m_ifv = 1'b1; m_instr = skid.pop_front(); m_ipc = m_pc; m_ip4 = m_pc + 32'd4;
        end else if (!id_stall) begin
          m_ifv = 1'b0; m_instr = NOP;
        end
        m_pc = exp_pcd;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ifid(input logic [31:0] pc, input string nm);
    int unsigned n;
    n = 0;
    #1;
    while (!(ifid_valid === 1'b1 && ifid_pc == pc) && n < 20) begin
      tick();
      #1;
      n++;
    end
    chk({nm, "_valid"}, ifid_valid, 1'b1);
    chk(nm, ifid_pc, pc);
  endtask

  task automatic wait_req(input logic [31:0] a, input string nm, output int unsigned n);
    n = 0;
    #1;
    while (!(imem_req === 1'b1 && imem_addr == a) && n < 20) begin
      tick();
      #1;
      n++;
    end
    chk({nm, "_req"}, imem_req, 1'b1);
    chk(nm, imem_addr, a);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin : stim
    int unsigned n;
    logic [39:0] pat;
    reset = 1'b1; id_stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    repeat (3) tick();
    chk("rst_ifid_valid", ifid_valid, 1'b0);
    chk("rst_ifid_instr", ifid_instr, NOP);
    chk("rst_ifid_pc", ifid_pc, 32'h0);
    chk("rst_ifid_pc_plus4", ifid_pc_plus4, 32'h0);
    chk("rst_addr_err", addr_err, 1'b0);
    reset = 1'b0;

    // Sequential fetch with 1-cycle memory.
    #1 chk("first_req", imem_req, 1'b1);
    chk("first_addr", imem_addr, 32'h0);
    wait_ifid(32'h0, "seq_pc0");
    chk("seq_instr0", ifid_instr, 32'hA5A5_0000);
    chk("seq_p4_0", ifid_pc_plus4, 32'h4);
    wait_ifid(32'h4, "seq_pc4");
    chk("seq_instr4", ifid_instr, 32'hA5A5_0004);
    chk("seq_p4_4", ifid_pc_plus4, 32'h8);

    // Stall while the response for 8 arrives: skid, PC and IF/ID hold.
    id_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("stall_pc_d", pc_d, 32'h8);
      chk("stall_ifid_pc", ifid_pc, 32'h4);
      chk("stall_ifid_valid", ifid_valid, 1'b1);
      tick();
    end
    #1 chk("hold_no_req", imem_req, 1'b0);
    id_stall = 1'b0;
    #1 chk("unstall_pc_d", pc_d, 32'hC);
    tick();
    chk("skid_ifid_pc", ifid_pc, 32'h8);
    chk("skid_ifid_instr", ifid_instr, 32'hA5A5_0008);
    #1 chk("after_skid_addr", imem_addr, 32'hC);
    chk("after_skid_req", imem_req, 1'b1);

    // Redirect during WAIT with a slow response: stale word drained.
    mem_delay = 3;
    id_stall = 1'b1;
    tick();
    chk("pre_flush_valid", ifid_valid, 1'b1);
    redirect_valid = 1'b1; redirect_target = 32'h0000_0100;
    #1 chk("redir_pc_d", pc_d, 32'h100);
    tick();
    redirect_valid = 1'b0; id_stall = 1'b0; mem_delay = 1;
    chk("flush_valid", ifid_valid, 1'b0);
    chk("flush_instr", ifid_instr, NOP);
    wait_req(32'h100, "kill_req", n);
    chk("kill_drain_cycles", n, 32'd2);

    // Redirect coinciding with rvalid in WAIT: no KILL.
    tick();
    redirect_valid = 1'b1; redirect_target = 32'h0000_0040;
    tick();
    redirect_valid = 1'b0;
    #1 chk("same_cycle_req", imem_req, 1'b1);
    chk("same_cycle_addr", imem_addr, 32'h40);
    chk("same_cycle_valid", ifid_valid, 1'b0);
    chk("same_cycle_instr", ifid_instr, NOP);

    // Redirect in ISSUE to the top word; PC wraps on acceptance.
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
    #1 chk("wrap_redir_pc_d", pc_d, 32'hFFFF_FFFC);
    tick();
    redirect_valid = 1'b0;
    wait_req(32'hFFFF_FFFC, "wrap_req", n);
    tick();
    #1 chk("wrap_pc_d", pc_d, 32'h0);
    tick();
    chk("wrap_ifid_pc", ifid_pc, 32'hFFFF_FFFC);
    chk("wrap_p4", ifid_pc_plus4, 32'h0);
    chk("wrap_instr", ifid_instr, 32'h5A5A_FFFC);
    #1 chk("wrap_next_addr", imem_addr, 32'h0);

    // Misaligned redirect target.
    redirect_valid = 1'b1; redirect_target = 32'h0000_0102;
    #1 chk("mis_pc_d", pc_d, 32'h100);
    tick();
    redirect_valid = 1'b0;
    chk("mis_addr_err", addr_err, ALIGN_EN);
    wait_req(32'h100, "mis_req", n);

    // Mixed stalls, latencies and redirects under the model.
    pat = 40'hC3_5A96_E1B4;
    for (int i = 0; i < 40; i++) begin
      id_stall = pat[i];
      mem_delay = 1 + (i % 3);
      redirect_valid = (i == 17 || i == 31);
      redirect_target = (i == 17) ? 32'h200 : 32'h3F0;
      tick();
    end
    id_stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    #1 chk("sticky_addr_err", addr_err, ALIGN_EN);

    // Reset with a slow request outstanding.
    mem_delay = 3;
    repeat (2) tick();
    reset = 1'b1;
    repeat (2) tick();
    chk("rst2_valid", ifid_valid, 1'b0);
    chk("rst2_addr_err", addr_err, 1'b0);
    chk("rst2_pc", ifid_pc, 32'h0);
    reset = 1'b0; mem_delay = 1;
    #1 chk("rst2_req", imem_req, 1'b1);
    chk("rst2_addr", imem_addr, 32'h0);
    wait_ifid(32'h0, "rst2_ifid");
    chk("rst2_instr", ifid_instr, 32'hA5A5_0000);
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch control sitting around the PC register: consumes its current value (pc_q) and drives its next value (pc_d) every cycle.
- The PC register loads D unconditionally, so hold is expressed as pc_d = pc_q.
- Issues single-outstanding requests to instruction memory and captures returned instructions into the IF/ID pipeline register.
- Handles decode stall, branch/jump redirect and discard of in-flight responses.

Parameters:
- PC_STEP, 32'd4, sequential PC increment.
- NOP_INSTR, 32'h0000_0000, value driven on ifid_instr when a bubble is inserted.

Ports:
- clk  input  1  system clock, all state on posedge.
- reset  input  1  synchronous, active-high reset.
- pc_q  input  32  current PC (PC register Q).
- pc_d  output  32  next PC (PC register D), combinational.
- imem_req  output  1  one-cycle fetch request.
- imem_addr  output  32  fetch address, equals pc_q.
- imem_rvalid  input  1  response valid pulse, at least 1 cycle after imem_req.
- imem_rdata  input  32  instruction word, valid with imem_rvalid.
- redirect_valid  input  1  branch/jump taken, from a later stage.
- redirect_target  input  32  new PC.
- id_stall  input  1  decode cannot accept a new IF/ID entry.
- ifid_valid  output  1  IF/ID entry valid.
- ifid_instr  output  32  fetched instruction.
- ifid_pc  output  32  PC of ifid_instr.
- ifid_pc_plus4  output  32  ifid_pc + PC_STEP.
- addr_err  output  1  misaligned redirect flag (optional feature).

Behaviour:
- Reset (synchronous): state <= ISSUE, ifid_valid <= 0, ifid_instr <= NOP_INSTR, ifid_pc <= 0, ifid_pc_plus4 <= 0, skid buffer empty, addr_err <= 0.
- imem_req = (state==ISSUE) & ~reset. pc_d is don't-care while reset is high, because the PC register forces 0.
- Instruction memory shares the same reset and drops any outstanding response on reset. Reset mid-WAIT therefore needs no drain.
- Default pc_d = pc_q (hold). Arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 wraps to 0.
- States:
  - ISSUE: assert imem_req, imem_addr = pc_q. Next state WAIT. If redirect_valid in the same cycle, next state KILL, because a request cannot be cancelled.
  - WAIT: waiting for imem_rvalid.
    - On rvalid and (~id_stall | ~ifid_valid): write imem_rdata, pc_q and pc_q+PC_STEP into IF/ID; ifid_valid <= 1; pc_d = pc_q + PC_STEP; next state ISSUE.
    - On rvalid while id_stall & ifid_valid: store the word in the skid buffer; pc_d holds; next state HOLD.
  - HOLD: buffered instruction waiting. When id_stall = 0: move the buffer into IF/ID, pc_d = pc_q + PC_STEP, next state ISSUE.
  - KILL: a stale response is in flight. On rvalid: discard it, next state ISSUE.
- IF/ID hold and bubble rules:
  - If id_stall = 1, the IF/ID outputs hold their values.
  - If id_stall = 0 and no new word is written that cycle: ifid_valid <= 0, ifid_instr <= NOP_INSTR (bubble).
- Redirect has priority over every other event, in every state:
  - pc_d = redirect_target (low bits per optional feature).
  - ifid_valid <= 0 and ifid_instr <= NOP_INSTR next cycle, even if id_stall = 1 (flush).
  - Skid buffer is discarded.
  - Next state by current state:
    - ISSUE -> KILL.
    - WAIT without rvalid -> KILL.
    - WAIT with rvalid in the same cycle -> ISSUE; the response is discarded.
    - HOLD -> ISSUE.
    - KILL -> KILL, or ISSUE if rvalid arrives in the same cycle.
- Throughput: at best 1 instruction per 2 cycles (ISSUE, then WAIT with rvalid).
- Redirect-to-request latency: first request to the target issues at most 1 cycle after redirect_valid, plus any KILL drain.
- Never more than one outstanding request.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Defined:
  - addr_err is set sticky (cleared only by reset) in the cycle after any redirect_valid with redirect_target[1:0] != 2'b00.
  - pc_d uses {redirect_target[31:2], 2'b00}.
- Undefined:
  - addr_err is tied to 0.
  - pc_d still forces target[1:0] to 2'b00.

Test Plan:
1. Reset 3 cycles, then release; memory returns rvalid 1 cycle after each req with rdata = addr ^ 32'hA5A5_0000 -> requests at 0, 4, 8; ifid_instr = 32'hA5A5_0000, then 32'hA5A5_0004; ifid_pc_plus4 = 4, 8.
2. id_stall = 1 while ifid_valid = 1 and a response for addr 8 arrives -> HOLD; pc_d = 8 and IF/ID held for every stall cycle; stall drop -> ifid_pc = 8 next cycle, then request at 12.
3. redirect_valid with target 32'h0000_0100 during WAIT, rvalid 2 cycles later -> stale word never reaches IF/ID, ifid_valid = 0 next cycle, next request addr = 32'h100 after the drain.
4. redirect_valid and imem_rvalid in the same WAIT cycle, target 32'h40 -> response discarded; next cycle ISSUE with addr 32'h40, no KILL.
5. pc_q = 32'hFFFF_FFFC, response accepted -> pc_d = 0; ifid_pc_plus4 = 0.
6. With FETCH_ALIGN_CHECK_EN defined, redirect target 32'h0000_0102 -> next fetch addr 32'h100; addr_err = 1, staying high until reset. Without the macro: addr_err = 0, fetch addr also 32'h100.
